// File: rtl/lcd_pkg.sv
// Shared types for the LCD bring-up sequencer:
// FSM encoding, panel ID constants, strap decode.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_ID_SETTLE  = 3'd0,
    ST_ID_SAMPLE  = 3'd1,
    ST_PANEL_RST  = 3'd2,
    ST_PANEL_WAIT = 3'd3,
    ST_WAIT_INIT  = 3'd4,
    ST_RUN        = 3'd5
  } lcd_state_e;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  localparam logic [7:0] DUTY_MAX = 8'hFF;

  typedef struct packed {
    logic [15:0] id;
    logic        err;
  } id_dec_t;

  // Panel strap pins live on three RGB bus bits.
  function automatic logic [2:0] strap_code(
    input logic [15:0] rgb
  );
    return {rgb[4], rgb[10], rgb[15]};
  endfunction

  // Unknown codes fall back to the most common panel.
  function automatic id_dec_t decode_strap(
    input logic [2:0] code
  );
    id_dec_t d;
    d.id  = ID_4342;
    d.err = 1'b0;
    case (code)
      3'b000:  d.id = ID_4342;
      3'b001:  d.id = ID_7084;
      3'b010:  d.id = ID_7016;
      3'b100:  d.id = ID_4384;
      3'b101:  d.id = ID_1018;
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

  // Counter width for a modulus, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight ramp: duty climbs one step per
// RAMP_STEP cycles, 8-bit free-running PWM.
module lcd_bl_pwm
  import lcd_pkg::*;
#(
  parameter int RAMP_STEP = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic lcd_bl_o,
  output logic bl_full_o
);

  localparam int STEP_W = cnt_w(RAMP_STEP);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(RAMP_STEP - 1);

  logic [STEP_W-1:0] step_q;
  logic [7:0]        duty_q;
  logic [7:0]        pwm_q;
  logic              bl_q;
  logic              full_q;

  // Ramp duty with saturation and compare
  // against the PWM phase; clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
      bl_q   <= 1'b0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      step_q <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
      bl_q   <= 1'b0;
      full_q <= 1'b0;
    end else if (en_i) begin
      pwm_q <= pwm_q + 8'd1;
      bl_q  <= (pwm_q < duty_q);
      if (step_q == STEP_LAST) begin
        step_q <= '0;
        if (duty_q != DUTY_MAX) begin
          duty_q <= duty_q + 8'd1;
          full_q <= (duty_q == DUTY_MAX - 8'd1);
        end
      end else begin
        step_q <= step_q + STEP_W'(1);
      end
    end
  end

  assign lcd_bl_o  = bl_q;
  assign bl_full_o = full_q;

endmodule

// File: rtl/lcd_bring_up_ctrl.sv
// LCD power-up sequencer: panel ID strap read,
// panel reset, init wait, then backlight ramp.
module lcd_bring_up_ctrl
  import lcd_pkg::*;
#(
  parameter int ID_SETTLE_CYC = 1000,
  parameter int ID_GAP_CYC    = 16,
  parameter int ID_RETRIES    = 3,
  parameter int RST_CYC       = 5000,
  parameter int WAIT_CYC      = 10000,
  parameter int RAMP_STEP     = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_init_done,
  input  logic [15:0] lcd_rgb_i,
  input  logic        post_de,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output logic        lcd_rst_n,
  output logic        drv_rst_n,
  output logic        bus_oe,
  output logic        lcd_bl,
  output logic        bl_full,
  output logic [2:0]  state_o
);

  localparam logic [15:0] SETTLE_LAST =
    16'(ID_SETTLE_CYC - 1);
  localparam logic [15:0] GAP_LAST =
    16'(ID_GAP_CYC - 1);
  localparam logic [15:0] RST_LAST =
    16'(RST_CYC - 1);
  localparam logic [15:0] WAIT_LAST =
    16'(WAIT_CYC - 1);

  localparam int RTRY_W = cnt_w(ID_RETRIES + 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX =
    RTRY_W'(ID_RETRIES);

  lcd_state_e        state_q;
  logic [15:0]       cnt_q;
  logic [RTRY_W-1:0] rtry_q;
  logic [2:0]        code_a_q;
  logic [15:0]       lcd_id_q;
  logic              id_valid_q;
  logic              id_err_q;
  logic              lcd_rst_n_q;
  logic              drv_rst_n_q;

  logic [2:0] code_b;
  id_dec_t    dec_b;
  logic       in_run;
  logic       pwm_en;
  logic       pwm_clr;

  assign code_b  = strap_code(lcd_rgb_i);
  assign dec_b   = decode_strap(code_b);
  assign in_run  = (state_q == ST_RUN);
  assign pwm_en  = in_run;
  assign pwm_clr = ~in_run | ~sys_init_done;

  // Sequencer: state, shared phase counter,
  // ID capture and all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_ID_SETTLE;
      cnt_q       <= '0;
      rtry_q      <= '0;
      code_a_q    <= '0;
      lcd_id_q    <= '0;
      id_valid_q  <= 1'b0;
      id_err_q    <= 1'b0;
      lcd_rst_n_q <= 1'b1;
      drv_rst_n_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      unique case (state_q)
        ST_ID_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            code_a_q <= code_b;
            cnt_q    <= '0;
            state_q  <= ST_ID_SAMPLE;
          end
        end
        ST_ID_SAMPLE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (code_b == code_a_q ||
                rtry_q == RTRY_MAX) begin
              lcd_id_q    <= dec_b.id;
              id_valid_q  <= 1'b1;
              id_err_q    <= dec_b.err |
                             (code_b != code_a_q);
              lcd_rst_n_q <= 1'b0;
              state_q     <= ST_PANEL_RST;
            end else begin
              code_a_q <= code_b;
              rtry_q   <= rtry_q + RTRY_W'(1);
            end
          end
        end
        ST_PANEL_RST: begin
          if (cnt_q == RST_LAST) begin
            lcd_rst_n_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_PANEL_WAIT;
          end
        end
        ST_PANEL_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          cnt_q <= '0;
          if (sys_init_done) begin
            drv_rst_n_q <= 1'b1;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_q <= '0;
          if (!sys_init_done) begin
            drv_rst_n_q <= 1'b0;
            state_q     <= ST_WAIT_INIT;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_ID_SETTLE;
        end
      endcase
    end
  end

  lcd_bl_pwm #(
    .RAMP_STEP(RAMP_STEP)
  ) u_bl (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .en_i     (pwm_en),
    .clear_i  (pwm_clr),
    .lcd_bl_o (lcd_bl),
    .bl_full_o(bl_full)
  );

  assign bus_oe    = in_run & post_de;
  assign lcd_id    = lcd_id_q;
  assign id_valid  = id_valid_q;
  assign id_err    = id_err_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign drv_rst_n = drv_rst_n_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lcd_bring_up_ctrl.sv
// Scoreboard bench for lcd_bring_up_ctrl:
// timed expectations checked by a monitor.
module tb_lcd_bring_up_ctrl;

  localparam int S_ID  = 0;
  localparam int S_VLD = 1;
  localparam int S_ERR = 2;
  localparam int S_PRN = 3;
  localparam int S_DRN = 4;
  localparam int S_OE  = 5;
  localparam int S_BL  = 6;
  localparam int S_FUL = 7;
  localparam int S_ST  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        post_de = 1'b0;
  logic [15:0] rgb = 16'h0;

  logic [15:0] lcd_id;
  logic        id_valid, id_err;
  logic        lcd_rst_n, drv_rst_n;
  logic        bus_oe, lcd_bl, bl_full;
  logic [2:0]  state_o;

  lcd_bring_up_ctrl #(
    .ID_SETTLE_CYC(8),
    .ID_GAP_CYC   (2),
    .ID_RETRIES   (2),
    .RST_CYC      (4),
    .WAIT_CYC     (4),
    .RAMP_STEP    (2)
  ) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .sys_init_done(init_done),
    .lcd_rgb_i    (rgb),
    .post_de      (post_de),
    .lcd_id       (lcd_id),
    .id_valid     (id_valid),
    .id_err       (id_err),
    .lcd_rst_n    (lcd_rst_n),
    .drv_rst_n    (drv_rst_n),
    .bus_oe       (bus_oe),
    .lcd_bl       (lcd_bl),
    .bl_full      (bl_full),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tick = 0;
  int   b = 0;

  always @(posedge clk) tick <= tick + 1;

  function automatic string sname(input int s);
    case (s)
      S_ID:    return "lcd_id";
      S_VLD:   return "id_valid";
      S_ERR:   return "id_err";
      S_PRN:   return "lcd_rst_n";
      S_DRN:   return "drv_rst_n";
      S_OE:    return "bus_oe";
      S_BL:    return "lcd_bl";
      S_FUL:   return "bl_full";
      default: return "state";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int s);
    case (s)
      S_ID:    return lcd_id;
      S_VLD:   return 16'(id_valid);
      S_ERR:   return 16'(id_err);
      S_PRN:   return 16'(lcd_rst_n);
      S_DRN:   return 16'(drv_rst_n);
      S_OE:    return 16'(bus_oe);
      S_BL:    return 16'(lcd_bl);
      S_FUL:   return 16'(bl_full);
      default: return 16'(state_o);
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @tick %0d: got %h want %h",
               nm, tick, act, exp);
    end
  endtask

  // Monitor: compare every expectation due now.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == tick) begin
        check(sname(sb[i].sig), actual(sb[i].sig),
              sb[i].val);
        sb.delete(i);
      end else if (sb[i].t < tick) begin
        checks++;
        errors++;
        $display("FAIL %s late: due %0d now %0d",
                 sname(sb[i].sig), sb[i].t, tick);
        sb.delete(i);
      end
    end
  end

  task automatic ex(input int t, input int s,
                    input logic [15:0] v);
    sb.push_back('{t, s, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (tick < t) step();
  endtask

  task automatic push_reset(input int t);
    ex(t, S_ID, 16'h0);
    ex(t, S_VLD, 16'd0);
    ex(t, S_ERR, 16'd0);
    ex(t, S_PRN, 16'd1);
    ex(t, S_DRN, 16'd0);
    ex(t, S_OE, 16'd0);
    ex(t, S_BL, 16'd0);
    ex(t, S_FUL, 16'd0);
    ex(t, S_ST, 16'd0);
  endtask

  // After this, DUT state after edge k shows at tick b+k.
  task automatic start(input logic [15:0] strap,
                       input logic idn);
    rst = 1'b1;
    rgb = strap;
    init_done = idn;
    post_de = 1'b1;
    step();
    step();
    push_reset(tick);
    step();
    rst = 1'b0;
    b = tick + 1;
  endtask

  int r;
  int x;
  int ones;

  initial begin
    // 1: stable code 001, init already done
    start(16'h8000, 1'b1);
    ex(b + 3, S_OE, 16'd0);
    ex(b + 6, S_ST, 16'd0);
    ex(b + 7, S_ST, 16'd1);
    ex(b + 8, S_VLD, 16'd0);
    ex(b + 8, S_PRN, 16'd1);
    ex(b + 9, S_ID, 16'h7084);
    ex(b + 9, S_VLD, 16'd1);
    ex(b + 9, S_ERR, 16'd0);
    ex(b + 9, S_PRN, 16'd0);
    ex(b + 9, S_OE, 16'd0);
    ex(b + 12, S_PRN, 16'd0);
    ex(b + 13, S_PRN, 16'd1);
    ex(b + 17, S_DRN, 16'd0);
    ex(b + 17, S_ST, 16'd4);
    ex(b + 17, S_OE, 16'd0);
    ex(b + 18, S_DRN, 16'd1);
    ex(b + 18, S_ST, 16'd5);
    ex(b + 18, S_OE, 16'd1);
    wait_until(b + 20);

    // 2: strap flips between every sample
    start(16'h0010, 1'b1);
    ex(b + 12, S_VLD, 16'd0);
    ex(b + 13, S_ID, 16'h4384);
    ex(b + 13, S_VLD, 16'd1);
    ex(b + 13, S_ERR, 16'd1);
    ex(b + 13, S_ST, 16'd2);
    ex(b + 17, S_PRN, 16'd1);
    for (int k = 1; k <= 14; k++) begin
      step();
      rgb = (((k / 2) % 2) == 1) ?
            16'h8000 : 16'h0010;
    end
    wait_until(b + 20);

    // 3: unknown strap code 111
    start(16'h8410, 1'b1);
    ex(b + 9, S_ID, 16'h4342);
    ex(b + 9, S_VLD, 16'd1);
    ex(b + 9, S_ERR, 16'd1);
    wait_until(b + 12);

    // 4: hold off init, post_de high
    start(16'h0000, 1'b0);
    ex(b + 9, S_ID, 16'h4342);
    ex(b + 9, S_ERR, 16'd0);
    ex(b + 17, S_ST, 16'd4);
    ex(b + 60, S_ST, 16'd4);
    ex(b + 60, S_DRN, 16'd0);
    ex(b + 60, S_OE, 16'd0);
    ex(b + 117, S_ST, 16'd4);
    ex(b + 117, S_DRN, 16'd0);
    ex(b + 117, S_OE, 16'd0);
    wait_until(b + 117);
    init_done = 1'b1;

    // 5: RUN, bus_oe follows post_de, ramp
    r = b + 118;
    ex(r, S_ST, 16'd5);
    ex(r, S_DRN, 16'd1);
    ex(r, S_OE, 16'd1);
    ex(r + 1, S_BL, 16'd0);
    ex(r + 509, S_FUL, 16'd0);
    ex(r + 510, S_FUL, 16'd1);
    ex(r + 1510, S_FUL, 16'd1);
    wait_until(r + 1);
    for (int i = 0; i < 6; i++) begin
      step();
      post_de = (i % 2) == 1;
      ex(tick, S_OE, 16'((i % 2) == 1));
    end
    wait_until(r + 600);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(lcd_bl);
    end
    check("bl_ones_full", 16'(ones), 16'd255);
    wait_until(r + 1200);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(lcd_bl);
    end
    check("bl_ones_late", 16'(ones), 16'd255);

    // 6: init drop in RUN, recover, then reset
    x = r + 1520;
    wait_until(x);
    init_done = 1'b0;
    ex(x + 1, S_DRN, 16'd0);
    ex(x + 1, S_BL, 16'd0);
    ex(x + 1, S_FUL, 16'd0);
    ex(x + 1, S_ST, 16'd4);
    ex(x + 1, S_PRN, 16'd1);
    wait_until(x + 1);
    init_done = 1'b1;
    ex(x + 2, S_ST, 16'd5);
    ex(x + 2, S_DRN, 16'd1);
    ex(x + 2, S_PRN, 16'd1);
    ex(x + 2, S_VLD, 16'd1);
    ex(x + 2, S_ID, 16'h4342);
    ex(x + 50, S_FUL, 16'd0);
    wait_until(x + 60);
    #2;
    rst = 1'b1;
    push_reset(tick);
    step();
    step();

    for (int i = 0; i < 5 && sb.size() != 0; i++)
      step();
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL pending: %0d unchecked",
               sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: tick %0d", tick);
    $fatal(1, "watchdog expired");
  end

endmodule
